cpu_alu: RTL and testbench

- 8-bit arithmetic/logic unit for the Beaker8 CPU core, instantiated by the CPU execute stage.
- Takes a 4-bit operation code, two 8-bit operands and the current 4-bit flag register.
- Produces a registered 8-bit result and an updated 4-bit flag set, one clock after the inputs are presented.

---
 rtl/cpu_alu.sv | 140 ++++++++++++++
 tb/tb_cpu_alu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// cpu_alu: Beaker8 8-bit ALU with registered result and flags (1-cycle latency).
// Flag layout: [0]=C, [1]=Z, [2]=N, [3]=V.
// Optional: define CPU_ALU_MUL_EN to make opcode F an unsigned multiply;
// otherwise opcode F passes rightOperand through.
`timescale 1ns/1ps
module cpu_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] operation,
  input  logic [3:0] flagsIn,
  input  logic [7:0] leftOperand,
  input  logic [7:0] rightOperand,
  output logic [7:0] resultOut,
  output logic [3:0] flagsOut
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_ROL = 4'hC;
  localparam logic [3:0] OP_ROR = 4'hD;
  localparam logic [3:0] OP_NOT = 4'hE;
  localparam logic [3:0] OP_F   = 4'hF;

  logic       w_cin;
  logic       w_add_cin;
  logic       w_sub_cin;
  logic [8:0] w_add9;
  logic [8:0] w_sub9;
  logic       w_add_v;
  logic       w_sub_v;
  logic [7:0] w_res;
  logic [7:0] w_zn;
  logic       w_c;
  logic       w_v;
  logic [7:0] r_result;
  logic [3:0] r_flags;

  assign w_cin     = flagsIn[0];
  assign w_add_cin = (operation == OP_ADC) ? w_cin : 1'b0;
  assign w_sub_cin = (operation == OP_SBC) ? w_cin : 1'b0;

  // Shared 9-bit adder/subtractor; bit 8 is carry-out or borrow.
  assign w_add9  = {1'b0, leftOperand} + {1'b0, rightOperand} + {8'b0, w_add_cin};
  assign w_sub9  = {1'b0, leftOperand} - {1'b0, rightOperand} - {8'b0, w_sub_cin};
  assign w_add_v = (leftOperand[7] == rightOperand[7]) && (w_add9[7] != leftOperand[7]);
  assign w_sub_v = (leftOperand[7] != rightOperand[7]) && (w_sub9[7] != leftOperand[7]);

`ifdef CPU_ALU_MUL_EN
  logic [15:0] w_prod;
  assign w_prod = {8'b0, leftOperand} * {8'b0, rightOperand};
`endif

  // Opcode decode: result, carry and overflow; C defaults to preserved.
  always_comb begin
    w_res = '0;
    w_c   = w_cin;
    w_v   = 1'b0;
    case (operation)
      OP_ADD, OP_ADC: begin
        w_res = w_add9[7:0];
        w_c   = w_add9[8];
        w_v   = w_add_v;
      end
      OP_SUB, OP_SBC: begin
        w_res = w_sub9[7:0];
        w_c   = w_sub9[8];
        w_v   = w_sub_v;
      end
      OP_AND: w_res = leftOperand & rightOperand;
      OP_OR:  w_res = leftOperand | rightOperand;
      OP_XOR: w_res = leftOperand ^ rightOperand;
      OP_CMP: begin
        w_res = leftOperand;
        w_c   = w_sub9[8];
        w_v   = w_sub_v;
      end
      OP_INC: begin
        w_res = leftOperand + 8'd1;
        w_v   = (leftOperand == 8'h7F);
      end
      OP_DEC: begin
        w_res = leftOperand - 8'd1;
        w_v   = (leftOperand == 8'h80);
      end
      OP_SHL: begin
        w_res = {leftOperand[6:0], 1'b0};
        w_c   = leftOperand[7];
      end
      OP_SHR: begin
        w_res = {1'b0, leftOperand[7:1]};
        w_c   = leftOperand[0];
      end
      OP_ROL: begin
        w_res = {leftOperand[6:0], w_cin};
        w_c   = leftOperand[7];
      end
      OP_ROR: begin
        w_res = {w_cin, leftOperand[7:1]};
        w_c   = leftOperand[0];
      end
      OP_NOT: w_res = ~leftOperand;
      OP_F: begin
`ifdef CPU_ALU_MUL_EN
        w_res = w_prod[7:0];
        w_c   = |w_prod[15:8];
`else
        w_res = rightOperand;
`endif
      end
    endcase
  end

  // CMP reports Z/N of the difference while returning L as its result.
  assign w_zn = (operation == OP_CMP) ? w_sub9[7:0] : w_res;

  // Output register: captures every cycle, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_result <= w_res;
      r_flags  <= {w_v, w_zn[7], (w_zn == 8'h00), w_c};
    end
  end

  assign resultOut = r_result;
  assign flagsOut  = r_flags;

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: directed-vector bench for cpu_alu.
`timescale 1ns/1ps
module tb_cpu_alu;

  logic       clk;
  logic       reset;
  logic [3:0] operation;
  logic [3:0] flagsIn;
  logic [7:0] leftOperand;
  logic [7:0] rightOperand;
  logic [7:0] resultOut;
  logic [3:0] flagsOut;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] fin;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  cpu_alu dut (
    .clk          (clk),
    .reset        (reset),
    .operation    (operation),
    .flagsIn      (flagsIn),
    .leftOperand  (leftOperand),
    .rightOperand (rightOperand),
    .resultOut    (resultOut),
    .flagsOut     (flagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then wait for the capturing edge and settle 1ns past it.
  task automatic step(input logic [3:0] op, input logic [3:0] f,
                      input logic [7:0] l, input logic [7:0] r);
    operation    = op;
    flagsIn      = f;
    leftOperand  = l;
    rightOperand = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    operation = 4'h0; flagsIn = 4'h0; leftOperand = 8'h12; rightOperand = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resultOut !== 8'h00) begin
      failures++;
      $display("FAIL reset_result got=%h exp=00", resultOut);
    end
    checks++;
    if (flagsOut !== 4'h0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", flagsOut);
    end
    reset = 1'b1;
    step(4'h0, 4'h0, 8'h12, 8'h34);
    checks++;
    if (resultOut !== 8'h46 || flagsOut !== 4'h0) begin
      failures++;
      $display("FAIL reset_release got=%h/%b exp=46/0000", resultOut, flagsOut);
    end
  endtask

  task automatic test_arith;
    vec_t tbl [9] = '{
      '{4'h0, 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100},  // ADD signed overflow
      '{4'h0, 4'h0, 8'hFF, 8'h01, 8'h00, 4'b0011},  // ADD carry, zero
      '{4'h1, 4'h1, 8'hFF, 8'h00, 8'h00, 4'b0011},  // ADC with Cin
      '{4'h1, 4'h1, 8'h7F, 8'h00, 8'h80, 4'b1100},  // ADC overflow via Cin
      '{4'h2, 4'h0, 8'h10, 8'h20, 8'hF0, 4'b0101},  // SUB borrow
      '{4'h7, 4'h0, 8'h42, 8'h42, 8'h42, 4'b0010},  // CMP equal
      '{4'h2, 4'h0, 8'h80, 8'h01, 8'h7F, 4'b1000},  // SUB overflow
      '{4'h3, 4'h1, 8'h00, 8'h00, 8'hFF, 4'b0101},  // SBC borrow from Cin
      '{4'h3, 4'h1, 8'h50, 8'h10, 8'h3F, 4'b0000}   // SBC no borrow
    };
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].op, tbl[i].fin, tbl[i].l, tbl[i].r);
      checks++;
      if (resultOut !== tbl[i].res || flagsOut !== tbl[i].fl) begin
        failures++;
        $display("FAIL arith[%0d] op=%h got=%h/%b exp=%h/%b", i, tbl[i].op,
                 resultOut, flagsOut, tbl[i].res, tbl[i].fl);
      end
    end
  endtask

  task automatic test_logic_shift;
    vec_t tbl [13] = '{
      '{4'hC, 4'h1, 8'h80, 8'h00, 8'h01, 4'b0001},  // ROL
      '{4'hD, 4'h0, 8'h01, 8'h00, 8'h00, 4'b0011},  // ROR to zero
      '{4'hD, 4'h1, 8'h02, 8'h00, 8'h81, 4'b0100},  // ROR Cin in
      '{4'hB, 4'h0, 8'h81, 8'h00, 8'h40, 4'b0001},  // SHR
      '{4'hA, 4'h0, 8'h81, 8'h00, 8'h02, 4'b0001},  // SHL
      '{4'h4, 4'b1001, 8'hF0, 8'h0F, 8'h00, 4'b0011}, // AND keeps C, drops V
      '{4'h5, 4'b1110, 8'h0F, 8'h80, 8'h8F, 4'b0100}, // OR drops Z/V in
      '{4'h6, 4'h1, 8'hAA, 8'hAA, 8'h00, 4'b0011},  // XOR
      '{4'h8, 4'h1, 8'h7F, 8'hFF, 8'h80, 4'b1101},  // INC overflow, C kept
      '{4'h8, 4'h0, 8'hFF, 8'h00, 8'h00, 4'b0010},  // INC wrap, C kept 0
      '{4'h9, 4'h0, 8'h80, 8'h00, 8'h7F, 4'b1000},  // DEC overflow
      '{4'h9, 4'h0, 8'h00, 8'h00, 8'hFF, 4'b0100},  // DEC wrap
      '{4'hE, 4'h1, 8'h00, 8'h55, 8'hFF, 4'b0101}   // NOT
    };
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].op, tbl[i].fin, tbl[i].l, tbl[i].r);
      checks++;
      if (resultOut !== tbl[i].res || flagsOut !== tbl[i].fl) begin
        failures++;
        $display("FAIL logic[%0d] op=%h got=%h/%b exp=%h/%b", i, tbl[i].op,
                 resultOut, flagsOut, tbl[i].res, tbl[i].fl);
      end
    end
  endtask

  task automatic test_opf;
`ifdef CPU_ALU_MUL_EN
    step(4'hF, 4'h0, 8'h10, 8'h10);
    checks++;
    if (resultOut !== 8'h00 || flagsOut !== 4'b0011) begin
      failures++;
      $display("FAIL mul_hi got=%h/%b exp=00/0011", resultOut, flagsOut);
    end
    step(4'hF, 4'h1, 8'h0F, 8'h11);
    checks++;
    if (resultOut !== 8'hFF || flagsOut !== 4'b0100) begin
      failures++;
      $display("FAIL mul_lo got=%h/%b exp=ff/0100", resultOut, flagsOut);
    end
`else
    step(4'hF, 4'h0, 8'h10, 8'h9C);
    checks++;
    if (resultOut !== 8'h9C || flagsOut !== 4'b0100) begin
      failures++;
      $display("FAIL pass_r got=%h/%b exp=9c/0100", resultOut, flagsOut);
    end
    step(4'hF, 4'hF, 8'h10, 8'h00);
    checks++;
    if (resultOut !== 8'h00 || flagsOut !== 4'b0011) begin
      failures++;
      $display("FAIL pass_zero got=%h/%b exp=00/0011", resultOut, flagsOut);
    end
`endif
  endtask

  // Outputs must hold the previous capture until the next rising edge.
  task automatic test_back_to_back;
    step(4'h0, 4'h0, 8'h01, 8'h02);
    operation = 4'h2; leftOperand = 8'h05; rightOperand = 8'h05;
    #2;
    checks++;
    if (resultOut !== 8'h03 || flagsOut !== 4'b0000) begin
      failures++;
      $display("FAIL latency_hold got=%h/%b exp=03/0000", resultOut, flagsOut);
    end
    @(posedge clk);
    #1;
    checks++;
    if (resultOut !== 8'h00 || flagsOut !== 4'b0010) begin
      failures++;
      $display("FAIL b2b_sub got=%h/%b exp=00/0010", resultOut, flagsOut);
    end
  endtask

  task automatic test_reset_midstream;
    step(4'h0, 4'h0, 8'h7F, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (resultOut !== 8'h00 || flagsOut !== 4'h0) begin
      failures++;
      $display("FAIL async_clear got=%h/%b exp=00/0000", resultOut, flagsOut);
    end
    #3;
    reset = 1'b1;
    step(4'h8, 4'h0, 8'h41, 8'h00);
    checks++;
    if (resultOut !== 8'h42 || flagsOut !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset got=%h/%b exp=42/0000", resultOut, flagsOut);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic_shift;
    test_opf;
    test_back_to_back;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
